id_stage_pipe: RTL and testbench

Parametrised successor to the instruction-decode stage. Decodes the instruction fields, generates the immediate, and reads a parametrised register file with write-through bypass from WB. It also detects load-use hazards and drives a registered ID/EX pipeline boundary with stall, flush and bubble insertion. Sits between the IF/ID register and EX in the 5-stage RISC-V core.

---
 rtl/riscv_pkg.sv | 68 ++++++
 rtl/regfile_bypass.sv | 66 ++++++
 rtl/id_stage_pipe.sv | 144 ++++++++++++++
 tb/tb_id_stage_pipe.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcodes, immediate formats, instruction
// field layout and the immediate generator used by the ID stage.
package riscv_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned REG_AW   = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // FMT_X marks an opcode outside the supported set.
    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X
    } imm_fmt_e;

    // Overlay of a 32-bit instruction word, MSB first.
    typedef struct packed {
        logic [6:0]        funct7;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rs1;
        logic [2:0]        funct3;
        logic [REG_AW-1:0] rd;
        logic [6:0]        opcode;
    } rv_fields_t;

    // Control half of the ID/EX boundary.
    typedef struct packed {
        logic       valid;
        logic       illegal;
        rv_fields_t ins;
    } idex_ctrl_t;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
        imm_fmt_e f;
        case (op)
            OP_R:                      f = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  f = FMT_I;
            OP_STORE:                  f = FMT_S;
            OP_BRANCH:                 f = FMT_B;
            OP_LUI, OP_AUIPC:          f = FMT_U;
            OP_JAL:                    f = FMT_J;
            default:                   f = FMT_X;
        endcase
        return f;
    endfunction

    // 32-bit sign-extended immediate; the caller widens to XLEN.
    function automatic logic [31:0] imm32(input logic [31:0] ins);
        logic [31:0] imm;
        case (imm_fmt(ins[6:0]))
            FMT_I:   imm = {{20{ins[31]}}, ins[31:20]};
            FMT_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            FMT_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            FMT_U:   imm = {ins[31:12], 12'b0};
            FMT_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// NREGS x XLEN register file, two combinational read ports, one write port.
// x0 reads zero, out-of-range indices read zero and are never written,
// optional same-cycle write-to-read bypass.
// Ports: clk, rst_n (sync, clears all entries), we/waddr/wdata write port,
//        raddr1/raddr2 -> rdata1/rdata2 read ports.
module regfile_bypass
    import riscv_pkg::*;
#(
    parameter int unsigned NREGS     = 32,
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned BYPASS_WB = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    output logic [XLEN-1:0]   rdata1_o,
    output logic [XLEN-1:0]   rdata2_o
);

    localparam int unsigned AW   = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned LIMW = REG_AW + 1;
    localparam logic [LIMW-1:0] NREGS_LIM = LIMW'(NREGS);

    logic [XLEN-1:0]   mem_q [NREGS];
    logic              wr_ok;
    logic [REG_AW-1:0] raddr [2];
    logic [XLEN-1:0]   rdata [2];

    // Writes to x0 or beyond the implemented file are dropped.
    assign wr_ok = we_i && (waddr_i != '0) && ({1'b0, waddr_i} < NREGS_LIM);

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NREGS); i++) begin
            if (!rst_n) begin
                mem_q[i] <= '0;
            end else if (wr_ok && (waddr_i[AW-1:0] == AW'(i))) begin
                mem_q[i] <= wdata_i;
            end
        end
    end

    assign raddr[0] = raddr1_i;
    assign raddr[1] = raddr2_i;

    // Read ports: zero for x0 / out of range, else bypass or array.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            if ((raddr[p] != '0) && ({1'b0, raddr[p]} < NREGS_LIM)) begin
                if ((BYPASS_WB != 0) && we_i && (waddr_i == raddr[p])) begin
                    rdata[p] = wdata_i;
                end else begin
                    rdata[p] = mem_q[raddr[p][AW-1:0]];
                end
            end
        end
    end

    assign rdata1_o = rdata[0];
    assign rdata2_o = rdata[1];

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: field slicing, immediate generation, register
// read with WB bypass, load-use hazard detection and the ID/EX register.
// Inputs: ID instruction/PC/valid, EX stall/flush, EX load info, WB write.
// Outputs: HAZARD_STALL (combinational), registered *_EX fields, ILLEGAL_EX.
module id_stage_pipe
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned BYPASS_WB = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   PC_ID,
    input  logic [31:0]       INSTRUCTION_ID,
    input  logic              VALID_ID,
    input  logic              STALL_EX,
    input  logic              FLUSH_EX,
    input  logic              MEMREAD_EX,
    input  logic [REG_AW-1:0] RD_EX,
    input  logic              RegWrite_WB,
    input  logic [REG_AW-1:0] RD_WB,
    input  logic [XLEN-1:0]   ALU_DATA_WB,
    output logic              HAZARD_STALL,
    output logic              VALID_EX,
    output logic [XLEN-1:0]   PC_EX,
    output logic [XLEN-1:0]   IMM_EX,
    output logic [XLEN-1:0]   REG_DATA1_EX,
    output logic [XLEN-1:0]   REG_DATA2_EX,
    output logic [2:0]        FUNCT3_EX,
    output logic [6:0]        FUNCT7_EX,
    output logic [6:0]        OPCODE_EX,
    output logic [REG_AW-1:0] RD_EX_O,
    output logic [REG_AW-1:0] RS1_EX,
    output logic [REG_AW-1:0] RS2_EX,
    output logic              ILLEGAL_EX
);

    localparam int unsigned LIMW = REG_AW + 1;
    localparam logic [LIMW-1:0] NREGS_LIM = LIMW'(NREGS);

    rv_fields_t      ins;
    imm_fmt_e        fmt;
    logic            uses_rs1, uses_rs2, writes_rd, illegal;
    logic [XLEN-1:0] rdata1, rdata2;

    idex_ctrl_t      ctrl_q, ctrl_d;
    logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d, rd1_q, rd1_d, rd2_q, rd2_d;

    assign ins = rv_fields_t'(INSTRUCTION_ID);
    assign fmt = imm_fmt(ins.opcode);

    assign uses_rs1  = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    assign uses_rs2  = fmt inside {FMT_R, FMT_S, FMT_B};
    assign writes_rd = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};

    assign illegal = VALID_ID && ((fmt == FMT_X)
                   || (uses_rs1  && ({1'b0, ins.rs1} >= NREGS_LIM))
                   || (uses_rs2  && ({1'b0, ins.rs2} >= NREGS_LIM))
                   || (writes_rd && ({1'b0, ins.rd}  >= NREGS_LIM)));

    regfile_bypass #(
        .NREGS     (NREGS),
        .XLEN      (XLEN),
        .BYPASS_WB (BYPASS_WB)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we_i     (RegWrite_WB),
        .waddr_i  (RD_WB),
        .wdata_i  (ALU_DATA_WB),
        .raddr1_i (ins.rs1),
        .raddr2_i (ins.rs2),
        .rdata1_o (rdata1),
        .rdata2_o (rdata2)
    );

    // Load-use check against whatever EX currently holds (including a held one).
    assign HAZARD_STALL = VALID_ID && MEMREAD_EX && ctrl_q.valid && (RD_EX != '0)
                        && ((uses_rs1 && (RD_EX == ins.rs1))
                         || (uses_rs2 && (RD_EX == ins.rs2)));

    // ID/EX next state: flush > stall > bubble > capture.
    always_comb begin
        ctrl_d = ctrl_q;
        pc_d   = pc_q;
        imm_d  = imm_q;
        rd1_d  = rd1_q;
        rd2_d  = rd2_q;
        if (FLUSH_EX) begin
            ctrl_d = '0;
            pc_d   = '0;
            imm_d  = '0;
            rd1_d  = '0;
            rd2_d  = '0;
        end else if (STALL_EX) begin
            ctrl_d = ctrl_q;
        end else if (HAZARD_STALL) begin
            ctrl_d = '0;
            pc_d   = '0;
            imm_d  = '0;
            rd1_d  = '0;
            rd2_d  = '0;
        end else begin
            ctrl_d.valid   = VALID_ID;
            ctrl_d.illegal = illegal;
            ctrl_d.ins     = ins;
            pc_d           = PC_ID;
            imm_d          = XLEN'($signed(imm32(INSTRUCTION_ID)));
            rd1_d          = rdata1;
            rd2_d          = rdata2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            pc_q   <= '0;
            imm_q  <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            pc_q   <= pc_d;
            imm_q  <= imm_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
        end
    end

    assign VALID_EX     = ctrl_q.valid;
    assign ILLEGAL_EX   = ctrl_q.illegal;
    assign PC_EX        = pc_q;
    assign IMM_EX       = imm_q;
    assign REG_DATA1_EX = rd1_q;
    assign REG_DATA2_EX = rd2_q;
    assign FUNCT3_EX    = ctrl_q.ins.funct3;
    assign FUNCT7_EX    = ctrl_q.ins.funct7;
    assign OPCODE_EX    = ctrl_q.ins.opcode;
    assign RD_EX_O      = ctrl_q.ins.rd;
    assign RS1_EX       = ctrl_q.ins.rs1;
    assign RS2_EX       = ctrl_q.ins.rs2;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: instance a = RV32I with bypass,
// instance b = RV32E (16 regs) without bypass, both fed the same stimulus.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_id, instr, wb_data;
    logic        valid_id, stall, flush, memread, wb_we;
    logic [4:0]  rd_ex, wb_rd;

    logic        a_hz, a_valid, a_ill, b_hz, b_valid, b_ill;
    logic [31:0] a_pc, a_imm, a_rd1, a_rd2, b_pc, b_imm, b_rd1, b_rd2;
    logic [2:0]  a_f3, b_f3;
    logic [6:0]  a_f7, a_op, b_f7, b_op;
    logic [4:0]  a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .NREGS(32), .BYPASS_WB(1)) u_a (
        .clk(clk), .rst_n(rst_n), .PC_ID(pc_id), .INSTRUCTION_ID(instr),
        .VALID_ID(valid_id), .STALL_EX(stall), .FLUSH_EX(flush),
        .MEMREAD_EX(memread), .RD_EX(rd_ex), .RegWrite_WB(wb_we),
        .RD_WB(wb_rd), .ALU_DATA_WB(wb_data), .HAZARD_STALL(a_hz),
        .VALID_EX(a_valid), .PC_EX(a_pc), .IMM_EX(a_imm),
        .REG_DATA1_EX(a_rd1), .REG_DATA2_EX(a_rd2), .FUNCT3_EX(a_f3),
        .FUNCT7_EX(a_f7), .OPCODE_EX(a_op), .RD_EX_O(a_rd), .RS1_EX(a_rs1),
        .RS2_EX(a_rs2), .ILLEGAL_EX(a_ill)
    );

    id_stage_pipe #(.XLEN(32), .NREGS(16), .BYPASS_WB(0)) u_b (
        .clk(clk), .rst_n(rst_n), .PC_ID(pc_id), .INSTRUCTION_ID(instr),
        .VALID_ID(valid_id), .STALL_EX(stall), .FLUSH_EX(flush),
        .MEMREAD_EX(memread), .RD_EX(rd_ex), .RegWrite_WB(wb_we),
        .RD_WB(wb_rd), .ALU_DATA_WB(wb_data), .HAZARD_STALL(b_hz),
        .VALID_EX(b_valid), .PC_EX(b_pc), .IMM_EX(b_imm),
        .REG_DATA1_EX(b_rd1), .REG_DATA2_EX(b_rd2), .FUNCT3_EX(b_f3),
        .FUNCT7_EX(b_f7), .OPCODE_EX(b_op), .RD_EX_O(b_rd), .RS1_EX(b_rs1),
        .RS2_EX(b_rs2), .ILLEGAL_EX(b_ill)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_id = 1'b0; stall = 1'b0; flush = 1'b0; memread = 1'b0;
        rd_ex = 5'd0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        instr = 32'h0000_0013; pc_id = 32'd0;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        wb_we = 1'b1; wb_rd = r; wb_data = d;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] ins);
        valid_id = 1'b1; pc_id = pc; instr = ins;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        step(); step();
        chk("rst_valid_a", 32'(a_valid), 32'd0);
        chk("rst_imm_a",   a_imm, 32'd0);
        chk("rst_pc_a",    a_pc, 32'd0);
        chk("rst_valid_b", 32'(b_valid), 32'd0);
        rst_n = 1'b1;

        // addi x5,x0,-1
        issue(32'h100, 32'hFFF0_0293); step();
        chk("addi_valid", 32'(a_valid), 32'd1);
        chk("addi_imm",   a_imm, 32'hFFFF_FFFF);
        chk("addi_rd",    32'(a_rd), 32'd5);
        chk("addi_rd1",   a_rd1, 32'd0);
        chk("addi_pc",    a_pc, 32'h100);
        chk("addi_ill",   32'(a_ill), 32'd0);

        // preload x1, x2, x4
        idle();
        wb(5'd1, 32'hA5A5_A5A5); step();
        wb(5'd2, 32'h0000_0022); step();
        wb(5'd4, 32'h0000_4444); step();
        idle();

        // add x8,x7,x7 while WB writes x7
        wb(5'd7, 32'h1234); issue(32'h104, 32'h0073_8433); step();
        chk("byp_a_rd1", a_rd1, 32'h1234);
        chk("byp_a_rd2", a_rd2, 32'h1234);
        chk("byp_b_rd1", b_rd1, 32'd0);
        chk("byp_b_rd2", b_rd2, 32'd0);
        wb_we = 1'b0; step();
        chk("commit_b_rd1", b_rd1, 32'h1234);

        // load-use: EX = lw x3, ID = add x4,x3,x1
        memread = 1'b1; rd_ex = 5'd3; issue(32'h108, 32'h0011_8233); #1;
        chk("hz_rs1_a", 32'(a_hz), 32'd1);
        chk("hz_rs1_b", 32'(b_hz), 32'd1);
        step();
        chk("bubble_valid", 32'(a_valid), 32'd0);
        chk("hz_ex_invalid", 32'(a_hz), 32'd0);
        memread = 1'b0; issue(32'h10C, 32'hFFF0_0293); step();
        memread = 1'b1; issue(32'h110, 32'h1234_51B7); #1;
        chk("hz_lui", 32'(a_hz), 32'd0);
        issue(32'h110, 32'h0030_8233); #1;
        chk("hz_rs2", 32'(a_hz), 32'd1);
        rd_ex = 5'd0; #1;
        chk("hz_rd0", 32'(a_hz), 32'd0);
        memread = 1'b0; issue(32'h114, 32'h1234_51B7); step();
        chk("lui_imm", a_imm, 32'h1234_5000);
        chk("lui_rd",  32'(a_rd), 32'd3);

        // flush and stall together: flush wins
        issue(32'h118, 32'hFFF0_0293); flush = 1'b1; stall = 1'b1; step();
        chk("flush_a", 32'(a_valid), 32'd0);
        chk("flush_b", 32'(b_valid), 32'd0);

        // capture addi x6,x1,5 then hold for 3 cycles
        flush = 1'b0; stall = 1'b0; issue(32'h200, 32'h0050_8313); step();
        chk("cap_rd1", a_rd1, 32'hA5A5_A5A5);
        stall = 1'b1; issue(32'h300, 32'hFFF0_0293); wb(5'd1, 32'h0000_BEEF);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_valid", 32'(a_valid), 32'd1);
            chk("hold_pc",    a_pc, 32'h200);
            chk("hold_imm",   a_imm, 32'd5);
            chk("hold_rd1",   a_rd1, 32'hA5A5_A5A5);
            chk("hold_rd",    32'(a_rd), 32'd6);
            chk("hold_rs1",   32'(a_rs1), 32'd1);
            chk("hold_op",    32'(a_op), 32'h13);
        end
        stall = 1'b0; wb_we = 1'b0; issue(32'h204, 32'h0050_8313); step();
        chk("wb_during_stall", a_rd1, 32'h0000_BEEF);

        // register index range
        issue(32'h208, 32'h0020_88B3); step();
        chk("x17_a_ill", 32'(a_ill), 32'd0);
        chk("x17_b_ill", 32'(b_ill), 32'd1);
        idle(); wb(5'd20, 32'h5555); step();
        idle(); issue(32'h20C, 32'h0142_0533); step();
        chk("x4_a", a_rd1, 32'h4444);
        chk("x20_a", a_rd2, 32'h5555);
        chk("x4_b", b_rd1, 32'h4444);
        chk("x20_b", b_rd2, 32'd0);
        chk("x20_b_ill", 32'(b_ill), 32'd1);

        // unknown opcode, legality gated by VALID_ID
        issue(32'h210, 32'h0000_007F); step();
        chk("unk_ill", 32'(a_ill), 32'd1);
        chk("unk_imm", a_imm, 32'd0);
        valid_id = 1'b0; step();
        chk("unk_novalid_ill", 32'(a_ill), 32'd0);

        // immediates: beq -4096, jal +2, sw x2,-8(x1)
        issue(32'h214, 32'h8000_0063); step();
        chk("beq_imm", a_imm, 32'hFFFF_F000);
        issue(32'h218, 32'h0020_006F); step();
        chk("jal_imm", a_imm, 32'h0000_0002);
        issue(32'h21C, 32'hFE20_AC23); step();
        chk("sw_imm", a_imm, 32'hFFFF_FFF8);
        chk("sw_f3",  32'(a_f3), 32'd2);
        chk("sw_rd2", a_rd2, 32'h22);
        chk("sw_rd1", a_rd1, 32'h0000_BEEF);

        // write x0, read x0 same cycle and after
        wb(5'd0, 32'hDEAD); issue(32'h220, 32'h0000_04B3); step();
        chk("x0_byp_rd1", a_rd1, 32'd0);
        wb_we = 1'b0; step();
        chk("x0_rd2", a_rd2, 32'd0);

        // reset mid-stream
        issue(32'h224, 32'h0050_8313); rst_n = 1'b0; step();
        chk("mrst_valid", 32'(a_valid), 32'd0);
        chk("mrst_pc",    a_pc, 32'd0);
        rst_n = 1'b1; step();
        chk("mrst_valid2", 32'(a_valid), 32'd1);
        chk("mrst_x1",     a_rd1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
